event_fifo_packetizer: RTL and testbench
========================================

EVENT_FIFO_PACKETIZER -- requirements
Module: event_fifo_packetizer

Interface
REQ-001 Parameter g_HeaderWord, default x"EB90", 16-bit sync word emitted at frame start.
REQ-002 Parameter g_TrailerWord, default x"146F", 16-bit word emitted at frame end.
REQ-003 Ports, listed as name, direction, width, meaning:
- Clock  in  1  single clock for all logic.
- Reset_N  in  1  asynchronous, active-low reset.
REQ-004 Enable  in  1  packetizer run; when low, no new FIFO reads are issued.
REQ-005 FIFO_Empty  in  1  event FIFO empty flag.
REQ-006 FIFO_Q  in  18  event FIFO read data, valid exactly 1 cycle after FIFO_RE.
- [17:16] tag: 01 = event start, 00 = sample, 10 = event end, 11 = reserved.
- [15:0] payload.
REQ-007 FIFO_RE  out  1  event FIFO read strobe, one-cycle pulse.
REQ-008 TX_Ready  in  1  downstream accepts TX_Data when TX_Valid and TX_Ready are both high.
REQ-009 TX_Data  out  16  output word.
REQ-010 TX_Valid  out  1  output word valid.
REQ-011 TX_Start  out  1  qualifies the header word.
REQ-012 TX_End  out  1  qualifies the trailer word.
REQ-013 Event_Count  out  16  number of completed frames, wrapping.
REQ-014 Error_Sticky  out  1  protocol error seen; cleared only by reset.

Function
REQ-015 FSM states SHALL be IDLE, READ, LATCH, DECODE, SEND_HDR, SEND_EVN, SEND_SMP, SEND_CNT, SEND_TRL.
REQ-016 IDLE -> READ when Enable=1 and FIFO_Empty=0; FIFO_RE SHALL be high only in READ, for exactly one cycle.
REQ-017 READ -> LATCH; in LATCH, FIFO_Q SHALL be captured into an 18-bit holding register; LATCH -> DECODE.
REQ-018 DECODE dispatch:
- tag 01 with no frame open -> SEND_HDR.
- tag 00 with frame open -> SEND_SMP.
- tag 10 with frame open -> SEND_CNT.
REQ-019 SEND_HDR SHALL drive TX_Data=g_HeaderWord with TX_Start=1, then go to SEND_EVN, which drives TX_Data=payload (event number); the frame is then open.
REQ-020 SEND_SMP SHALL drive TX_Data=payload and increment the 16-bit sample counter, saturating at x"FFFF".
REQ-021 SEND_CNT SHALL drive TX_Data=sample counter, then go to SEND_TRL, which drives TX_Data=g_TrailerWord with TX_End=1.
- On acceptance in SEND_TRL: frame closes, sample counter clears, Event_Count increments (x"FFFF" wraps to 0).
REQ-022 In every SEND_* state, TX_Valid SHALL be 1 and TX_Data/TX_Start/TX_End SHALL stay stable until accepted; the state advances only on the accepting cycle.
REQ-023 After the last word of an item is accepted, the FSM SHALL go to READ if Enable=1 and FIFO_Empty=0, else to IDLE.
REQ-024 Tag 00 or 10 with no frame open SHALL be dropped with no TX output, and SHALL set Error_Sticky.
REQ-025 Tag 11 SHALL be dropped with no TX output, and SHALL set Error_Sticky.
REQ-026 Tag 01 with a frame already open SHALL set Error_Sticky, emit count and trailer for the open frame (counted in Event_Count), then emit header and event number for the new frame.
REQ-027 Enable deassertion SHALL NOT abort a word in progress or an item already latched; it only blocks the next READ.
REQ-028 FIFO_Empty SHALL be sampled only in the state that decides entry to READ; no read is issued while FIFO_Empty=1.
REQ-029 TX_Valid SHALL be 0 in IDLE, READ, LATCH and DECODE; TX_Start and TX_End SHALL be 0 whenever TX_Valid=0.

Reset
REQ-030 Reset_N low SHALL asynchronously force:
- state IDLE.
- FIFO_RE, TX_Valid, TX_Start, TX_End and Error_Sticky = 0.
- TX_Data, Event_Count, sample counter and holding register = 0.
- frame closed.
REQ-031 Reset asserted mid-frame SHALL discard the open frame with no trailer; after release, the first accepted tag-00 word SHALL set Error_Sticky.

Verification
REQ-032 FIFO holds {01,x"0007"},{00,x"0123"},{00,x"0456"},{10,x"0000"}, TX_Ready=1, Enable=1 -> TX sequence EB90(Start), 0007, 0123, 0456, 0002, 146F(End); Event_Count=1; Error_Sticky=0.
REQ-033 Same stimulus with TX_Ready toggling every 3 cycles -> identical word sequence, with no word lost or duplicated and outputs stable while stalled.
REQ-034 Single word {00,x"AAAA"} after reset -> no TX_Valid; Error_Sticky=1; one FIFO_RE pulse.
REQ-035 {01,1},{00,5},{01,2},{10,0} -> EB90, 0001, 0005, 0001, 146F, EB90, 0002, 0000, 146F; Event_Count=2; Error_Sticky=1.
REQ-036 Enable dropped during SEND_SMP with 3 words remaining in the FIFO -> current word completes, FIFO_RE stays 0; re-enable -> remaining words are output in order.
REQ-037 Reset pulsed during SEND_EVN -> all outputs 0 immediately; a subsequent full event is output correctly with Event_Count=1.

Source files
------------

// File: rtl/event_fifo_packetizer.sv
// Event FIFO packetizer: reads tagged event words from a FIFO and frames them
// as header / event number / samples / sample count / trailer on a
// valid-ready output stream.
module event_fifo_packetizer #(
  parameter logic [15:0] g_HeaderWord  = 16'hEB90,
  parameter logic [15:0] g_TrailerWord = 16'h146F
) (
  input  logic        Clock,
  input  logic        Reset_N,
  input  logic        Enable,
  input  logic        FIFO_Empty,
  input  logic [17:0] FIFO_Q,
  output logic        FIFO_RE,
  input  logic        TX_Ready,
  output logic [15:0] TX_Data,
  output logic        TX_Valid,
  output logic        TX_Start,
  output logic        TX_End,
  output logic [15:0] Event_Count,
  output logic        Error_Sticky
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ITEM_W = 18;

  localparam logic [1:0] TAG_SAMPLE = 2'b00;
  localparam logic [1:0] TAG_START  = 2'b01;
  localparam logic [1:0] TAG_END    = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    READ,
    LATCH,
    DECODE,
    SEND_HDR,
    SEND_EVN,
    SEND_SMP,
    SEND_CNT,
    SEND_TRL
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [ITEM_W-1:0]   hold;
  logic [DATA_W-1:0]   sample_cnt;
  logic                frame_open;
  logic                pending_hdr;

  logic                fifo_re_d;
  logic                tx_valid_d;
  logic                tx_start_d;
  logic                tx_end_d;
  logic [DATA_W-1:0]   tx_data_d;

  logic                accept;
  logic                can_read;
  logic [1:0]          tag;
  logic [DATA_W-1:0]   payload;
  logic                bad_item;

  assign accept   = TX_Valid & TX_Ready;
  assign can_read = Enable & ~FIFO_Empty;
  assign tag      = hold[17:16];
  assign payload  = hold[15:0];

  // Items that are dropped at decode: reserved tag, or sample/end with no open frame.
  assign bad_item = (tag == 2'b11) || ((tag != TAG_START) && !frame_open);

  // State register.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (can_read) state_d = READ;
      READ:     state_d = LATCH;
      LATCH:    state_d = DECODE;
      DECODE: begin
        if (bad_item) begin
          state_d = can_read ? READ : IDLE;
        end else begin
          unique case (tag)
            TAG_START:  state_d = frame_open ? SEND_CNT : SEND_HDR;
            TAG_SAMPLE: state_d = SEND_SMP;
            TAG_END:    state_d = SEND_CNT;
            default:    state_d = can_read ? READ : IDLE;
          endcase
        end
      end
      SEND_HDR: if (accept) state_d = SEND_EVN;
      SEND_EVN: if (accept) state_d = can_read ? READ : IDLE;
      SEND_SMP: if (accept) state_d = can_read ? READ : IDLE;
      SEND_CNT: if (accept) state_d = SEND_TRL;
      SEND_TRL: begin
        if (accept) begin
          if (pending_hdr) state_d = SEND_HDR;
          else             state_d = can_read ? READ : IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state.
  always_comb begin
    fifo_re_d  = 1'b0;
    tx_valid_d = 1'b0;
    tx_start_d = 1'b0;
    tx_end_d   = 1'b0;
    tx_data_d  = '0;
    unique case (state_d)
      READ:     fifo_re_d = 1'b1;
      SEND_HDR: begin
        tx_valid_d = 1'b1;
        tx_start_d = 1'b1;
        tx_data_d  = g_HeaderWord;
      end
      SEND_EVN, SEND_SMP: begin
        tx_valid_d = 1'b1;
        tx_data_d  = payload;
      end
      SEND_CNT: begin
        tx_valid_d = 1'b1;
        tx_data_d  = sample_cnt;
      end
      SEND_TRL: begin
        tx_valid_d = 1'b1;
        tx_end_d   = 1'b1;
        tx_data_d  = g_TrailerWord;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      FIFO_RE  <= 1'b0;
      TX_Valid <= 1'b0;
      TX_Start <= 1'b0;
      TX_End   <= 1'b0;
      TX_Data  <= '0;
    end else begin
      FIFO_RE  <= fifo_re_d;
      TX_Valid <= tx_valid_d;
      TX_Start <= tx_start_d;
      TX_End   <= tx_end_d;
      TX_Data  <= tx_data_d;
    end
  end

  // Item holding register, frame bookkeeping, counters and sticky error.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      hold         <= '0;
      sample_cnt   <= '0;
      frame_open   <= 1'b0;
      pending_hdr  <= 1'b0;
      Event_Count  <= '0;
      Error_Sticky <= 1'b0;
    end else begin
      if (state == LATCH) hold <= FIFO_Q;

      if (state == DECODE) begin
        if (bad_item) Error_Sticky <= 1'b1;
        if ((tag == TAG_START) && frame_open) begin
          Error_Sticky <= 1'b1;
          pending_hdr  <= 1'b1;
        end
      end

      if ((state == SEND_EVN) && accept) frame_open <= 1'b1;

      if ((state == SEND_SMP) && accept && (sample_cnt != 16'hFFFF)) begin
        sample_cnt <= sample_cnt + DATA_W'(1);
      end

      if ((state == SEND_TRL) && accept) begin
        frame_open  <= 1'b0;
        pending_hdr <= 1'b0;
        sample_cnt  <= '0;
        Event_Count <= Event_Count + DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_event_fifo_packetizer.sv
// Directed testbench for event_fifo_packetizer with a behavioural FIFO and
// an output word scoreboard.
module tb_event_fifo_packetizer;

  logic        Clock = 1'b0;
  logic        Reset_N = 1'b0;
  logic        Enable = 1'b0;
  logic        FIFO_Empty = 1'b1;
  logic [17:0] FIFO_Q = '0;
  logic        TX_Ready = 1'b0;
  logic        FIFO_RE;
  logic [15:0] TX_Data;
  logic        TX_Valid;
  logic        TX_Start;
  logic        TX_End;
  logic [15:0] Event_Count;
  logic        Error_Sticky;

  int n_tests = 0;
  int n_fail  = 0;
  int re_count = 0;
  int valid_seen = 0;
  int stall_seen = 0;
  logic stall_prev = 1'b0;
  logic [18:0] prev_word = '0;

  logic [17:0] fifo[$];
  logic [17:0] captured[$];
  logic [17:0] exp_q[$];

  event_fifo_packetizer dut (
    .Clock(Clock),
    .Reset_N(Reset_N),
    .Enable(Enable),
    .FIFO_Empty(FIFO_Empty),
    .FIFO_Q(FIFO_Q),
    .FIFO_RE(FIFO_RE),
    .TX_Ready(TX_Ready),
    .TX_Data(TX_Data),
    .TX_Valid(TX_Valid),
    .TX_Start(TX_Start),
    .TX_End(TX_End),
    .Event_Count(Event_Count),
    .Error_Sticky(Error_Sticky)
  );

  always #5 Clock = ~Clock;

  // Behavioural FIFO: data appears one cycle after the read strobe.
  always @(posedge Clock) begin
    if (FIFO_RE && (fifo.size() > 0)) FIFO_Q <= fifo.pop_front();
    FIFO_Empty <= (fifo.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: records accepted words, counts strobes, checks stall stability.
  always @(negedge Clock) begin
    if (Reset_N) begin
      if (FIFO_RE) re_count++;
      if (TX_Valid) valid_seen++;
      if (stall_prev) begin
        stall_seen++;
        check("stall_hold", 32'({TX_Valid, TX_Start, TX_End, TX_Data}), 32'(prev_word));
      end
      stall_prev = TX_Valid && !TX_Ready;
      prev_word  = {TX_Valid, TX_Start, TX_End, TX_Data};
      if (TX_Valid && TX_Ready) captured.push_back({TX_Start, TX_End, TX_Data});
    end
  end

  task automatic clear_monitor();
    captured.delete();
    re_count   = 0;
    valid_seen = 0;
    stall_seen = 0;
    stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    Reset_N  = 1'b0;
    Enable   = 1'b0;
    TX_Ready = 1'b0;
    fifo.delete();
    repeat (3) @(posedge Clock);
    #1;
    Reset_N = 1'b1;
    clear_monitor();
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && captured.size() < n; i++) @(posedge Clock);
    repeat (12) @(posedge Clock);
    #1;
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(captured.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < captured.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(captured[i]), 32'(exp_q[i]));
  endtask

  task automatic wait_word(input logic [15:0] data, output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge Clock);
      #1;
      if (TX_Valid && !TX_Start && (TX_Data == data)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int rc;
    int tc;

    // Reset values
    do_reset();
    check("rst_fifo_re", 32'(FIFO_RE), 32'd0);
    check("rst_tx_valid", 32'(TX_Valid), 32'd0);
    check("rst_tx_start", 32'(TX_Start), 32'd0);
    check("rst_tx_end", 32'(TX_End), 32'd0);
    check("rst_tx_data", 32'(TX_Data), 32'd0);
    check("rst_event_count", 32'(Event_Count), 32'd0);
    check("rst_error", 32'(Error_Sticky), 32'd0);

    // Basic frame
    fifo = '{18'h10007, 18'h00123, 18'h00456, 18'h20000};
    TX_Ready = 1'b1;
    Enable = 1'b1;
    wait_words(6, 300);
    exp_q = '{18'h2EB90, 18'h00007, 18'h00123, 18'h00456, 18'h00002, 18'h1146F};
    check_seq("basic");
    check("basic_event_count", 32'(Event_Count), 32'd1);
    check("basic_error", 32'(Error_Sticky), 32'd0);
    check("basic_re_pulses", 32'(re_count), 32'd4);

    // Same frame with TX_Ready toggling every 3 cycles
    do_reset();
    fifo = '{18'h10007, 18'h00123, 18'h00456, 18'h20000};
    Enable = 1'b1;
    TX_Ready = 1'b1;
    tc = 0;
    for (int i = 0; i < 600 && captured.size() < 6; i++) begin
      @(posedge Clock);
      #1;
      tc++;
      if (tc == 3) begin
        TX_Ready = ~TX_Ready;
        tc = 0;
      end
    end
    TX_Ready = 1'b1;
    wait_words(6, 10);
    check_seq("stall");
    check("stall_seen", 32'(stall_seen != 0), 32'd1);
    check("stall_event_count", 32'(Event_Count), 32'd1);
    check("stall_error", 32'(Error_Sticky), 32'd0);

    // Orphan sample after reset
    do_reset();
    fifo = '{18'h0AAAA};
    TX_Ready = 1'b1;
    Enable = 1'b1;
    repeat (30) @(posedge Clock);
    #1;
    check("orphan_valid_seen", 32'(valid_seen), 32'd0);
    check("orphan_error", 32'(Error_Sticky), 32'd1);
    check("orphan_re_pulses", 32'(re_count), 32'd1);
    check("orphan_event_count", 32'(Event_Count), 32'd0);

    // New event while a frame is open
    do_reset();
    fifo = '{18'h10001, 18'h00005, 18'h10002, 18'h20000};
    TX_Ready = 1'b1;
    Enable = 1'b1;
    wait_words(9, 400);
    exp_q = '{18'h2EB90, 18'h00001, 18'h00005, 18'h00001, 18'h1146F,
              18'h2EB90, 18'h00002, 18'h00000, 18'h1146F};
    check_seq("reopen");
    check("reopen_event_count", 32'(Event_Count), 32'd2);
    check("reopen_error", 32'(Error_Sticky), 32'd1);

    // Enable dropped while sending the first sample
    do_reset();
    fifo = '{18'h10009, 18'h00001, 18'h00002, 18'h00003, 18'h20000};
    TX_Ready = 1'b1;
    Enable = 1'b1;
    wait_word(16'h0001, found);
    check("pause_found_smp", 32'(found), 32'd1);
    Enable = 1'b0;
    rc = re_count;
    repeat (20) @(posedge Clock);
    #1;
    check("pause_no_read", 32'(re_count), 32'(rc));
    check("pause_words", 32'(captured.size()), 32'd3);
    check("pause_fifo_left", 32'(fifo.size()), 32'd3);
    Enable = 1'b1;
    wait_words(7, 300);
    exp_q = '{18'h2EB90, 18'h00009, 18'h00001, 18'h00002, 18'h00003, 18'h00003, 18'h1146F};
    check_seq("pause");
    check("pause_event_count", 32'(Event_Count), 32'd1);
    check("pause_error", 32'(Error_Sticky), 32'd0);

    // Reset pulsed during the event number word
    do_reset();
    fifo = '{18'h10005, 18'h00006, 18'h20000};
    TX_Ready = 1'b0;
    Enable = 1'b1;
    for (int i = 0; i < 100 && !TX_Start; i++) begin
      @(posedge Clock);
      #1;
    end
    TX_Ready = 1'b1;
    wait_word(16'h0005, found);
    check("midrst_found_evn", 32'(found), 32'd1);
    Reset_N = 1'b0;
    #1;
    check("midrst_ctl", 32'({FIFO_RE, TX_Valid, TX_Start, TX_End, Error_Sticky}), 32'd0);
    check("midrst_data", 32'(TX_Data), 32'd0);
    check("midrst_event_count", 32'(Event_Count), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset_N = 1'b1;
    clear_monitor();
    repeat (30) @(posedge Clock);
    #1;
    check("midrst_drop_valid", 32'(valid_seen), 32'd0);
    check("midrst_drop_error", 32'(Error_Sticky), 32'd1);
    fifo = '{18'h10008, 18'h00011, 18'h20000};
    wait_words(5, 300);
    exp_q = '{18'h2EB90, 18'h00008, 18'h00011, 18'h00001, 18'h1146F};
    check_seq("midrst");
    check("midrst_final_count", 32'(Event_Count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
